// File: rtl/reaction_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_pkg
//  Description : Shared definitions for the multi-player reaction-timer
//                controller: state encodings, LFSR tap mask, default LFSR
//                seed and the winner-index width function.
//  Revision    : 1.0 - initial release
// ============================================================================
package reaction_pkg;

    // State encodings, also exported on the STATE debug port.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_GO     = 3'd2;
    localparam logic [2:0] ST_RESULT = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Winner index width: max(1, clog2(n)).
    function automatic int pw_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : reaction_pkg
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11),
//                shifting left every clock. Used as the random source for
//                the arm delay.
//  Ports       : CLK   - system clock
//                RST_N - asynchronous active-low reset, loads SEED
//                q     - current LFSR contents
//  Parameters  : SEED  - reset value; must be non-zero (all-zero locks up)
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import reaction_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [15:0] q
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = ^(r_lfsr & LFSR_TAPS);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    assign q = r_lfsr;

endmodule : lfsr16
`default_nettype wire

// File: rtl/reaction_ctrl_mp.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_ctrl_mp
//  Description : Multi-player reaction-timer controller. Detects START and
//                PRESS rising edges, arms after a pseudo-random delay,
//                times the reaction in TICK units, detects false starts and
//                timeouts and arbitrates the winner (lowest index).
//  Ports       : CLK         in  system clock
//                RST_N       in  asynchronous active-low reset
//                TICK        in  one-cycle timebase pulse
//                START       in  start/clear key (rising edge)
//                PRESS       in  player buttons (rising edges)
//                LED         out stimulus lamp, high only in GO
//                TIME        out running / captured reaction time
//                WINNER      out winning (or false-starting) player index
//                VALID       out round finished with a winner
//                FALSE_START out press during WAIT
//                TIMEOUT     out nobody pressed before MAX_TIME
//                STATE       out current state encoding
//                BEST_TIME   out best valid time     (REACTION_BEST_TIME_EN)
//                NEW_BEST    out last round improved (REACTION_BEST_TIME_EN)
//  Macro       : REACTION_BEST_TIME_EN adds the best-time register and ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module reaction_ctrl_mp
    import reaction_pkg::*;
#(
    parameter int          NPLAYERS  = 2,
    parameter int          TIME_W    = 14,
    parameter int          MAX_TIME  = 9999,
    parameter int          MIN_DELAY = 1000,
    parameter int          RAND_BITS = 11,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT,
    localparam int         PW        = pw_width(NPLAYERS)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                TICK,
    input  logic                START,
    input  logic [NPLAYERS-1:0] PRESS,
    output logic                LED,
    output logic [TIME_W-1:0]   TIME,
    output logic [PW-1:0]       WINNER,
    output logic                VALID,
    output logic                FALSE_START,
    output logic                TIMEOUT,
    output logic [2:0]          STATE
`ifdef REACTION_BEST_TIME_EN
    ,
    output logic [TIME_W-1:0]   BEST_TIME,
    output logic                NEW_BEST
`endif
);

    localparam logic [TIME_W-1:0] c_max_time  = TIME_W'(MAX_TIME);
    localparam logic [15:0]       c_dly_base  = 16'(MIN_DELAY);
    localparam logic [15:0]       c_rand_mask = 16'((32'd1 << RAND_BITS) - 32'd1);

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic                r_start_q;
    logic [NPLAYERS-1:0] r_press_q;
    logic                r_edge_en;
    logic                w_start_rise;
    logic [NPLAYERS-1:0] w_press_rise;
    logic                w_any_press;

    // r_edge_en stays low for the first clock after reset release so a level
    // that was already high during reset is absorbed into the _q registers
    // instead of being seen as a rising edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_start_q <= 1'b0;
            r_press_q <= '0;
            r_edge_en <= 1'b0;
        end else begin
            r_start_q <= START;
            r_press_q <= PRESS;
            r_edge_en <= 1'b1;
        end
    end

    assign w_start_rise = r_edge_en & START & ~r_start_q;
    assign w_press_rise = {NPLAYERS{r_edge_en}} & PRESS & ~r_press_q;
    assign w_any_press  = |w_press_rise;

    // Lowest pressed index wins; scanning downward lets the lowest overwrite.
    logic [PW-1:0] w_win_idx;

    always_comb begin
        w_win_idx = '0;
        for (int i = NPLAYERS - 1; i >= 0; i--) begin
            if (w_press_rise[i]) begin
                w_win_idx = PW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Random source and counters
    // ------------------------------------------------------------------
    logic [15:0] w_lfsr;
    logic [15:0] w_dly_load;
    logic [15:0] r_dly_cnt;
    logic        w_dly_last;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .q     (w_lfsr)
    );

    assign w_dly_load = c_dly_base + (w_lfsr & c_rand_mask);
    // <= rather than == so a zero-length delay cannot wrap to 65535.
    assign w_dly_last = (r_dly_cnt <= 16'd1);

    logic [TIME_W-1:0] r_time;
    logic [TIME_W-1:0] w_time_inc;
    logic              w_time_hit;

    assign w_time_inc = r_time + TIME_W'(1);
    assign w_time_hit = (w_time_inc == c_max_time);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [2:0] w_next_state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A press wins over the final delay tick: it is a false start.
                if (w_any_press) begin
                    w_next_state = ST_FAULT;
                end else if (TICK && w_dly_last) begin
                    w_next_state = ST_GO;
                end
            end
            ST_GO: begin
                if (w_any_press) begin
                    w_next_state = ST_RESULT;
                end else if (TICK && w_time_hit) begin
                    w_next_state = ST_RESULT;
                end
            end
            ST_RESULT, ST_FAULT: begin
                if (w_start_rise) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: timer, delay counter, winner and flags
    // ------------------------------------------------------------------
    logic [PW-1:0] r_winner;
    logic          r_valid;
    logic          r_false_start;
    logic          r_timeout;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dly_cnt     <= '0;
            r_time        <= '0;
            r_winner      <= '0;
            r_valid       <= 1'b0;
            r_false_start <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_time        <= '0;
                    r_winner      <= '0;
                    r_valid       <= 1'b0;
                    r_false_start <= 1'b0;
                    r_timeout     <= 1'b0;
                    if (w_start_rise) begin
                        r_dly_cnt <= w_dly_load;
                    end
                end
                ST_WAIT: begin
                    if (w_any_press) begin
                        r_false_start <= 1'b1;
                        r_winner      <= w_win_idx;
                    end else if (TICK) begin
                        r_dly_cnt <= r_dly_cnt - 16'd1;
                        if (w_dly_last) begin
                            r_time <= '0;
                        end
                    end
                end
                ST_GO: begin
                    // A tick coinciding with the winning press is not counted.
                    if (w_any_press) begin
                        r_valid  <= 1'b1;
                        r_winner <= w_win_idx;
                    end else if (TICK) begin
                        r_time <= w_time_inc;
                        if (w_time_hit) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                ST_RESULT, ST_FAULT: begin
                    if (w_start_rise) begin
                        r_time        <= '0;
                        r_winner      <= '0;
                        r_valid       <= 1'b0;
                        r_false_start <= 1'b0;
                        r_timeout     <= 1'b0;
                    end
                end
                default: begin
                    r_time        <= '0;
                    r_winner      <= '0;
                    r_valid       <= 1'b0;
                    r_false_start <= 1'b0;
                    r_timeout     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        LED   = (r_state == ST_GO);
        STATE = r_state;
    end

    assign TIME        = r_time;
    assign WINNER      = r_winner;
    assign VALID       = r_valid;
    assign FALSE_START = r_false_start;
    assign TIMEOUT     = r_timeout;

`ifdef REACTION_BEST_TIME_EN
    // ------------------------------------------------------------------
    // Best-time tracking; survives round clears, only RST_N resets it.
    // ------------------------------------------------------------------
    logic [TIME_W-1:0] r_best_time;
    logic              r_new_best;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_best_time <= c_max_time;
            r_new_best  <= 1'b0;
        end else begin
            // r_time is held on the winning press, so it is the captured time.
            if (r_state == ST_GO && w_any_press && r_time < r_best_time) begin
                r_best_time <= r_time;
                r_new_best  <= 1'b1;
            end else if (w_start_rise) begin
                r_new_best <= 1'b0;
            end
        end
    end

    assign BEST_TIME = r_best_time;
    assign NEW_BEST  = r_new_best;
`endif

endmodule : reaction_ctrl_mp
`default_nettype wire

// File: tb/tb_reaction_ctrl_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_reaction_ctrl_mp
//  Description : Directed self-checking bench for reaction_ctrl_mp. Two
//                instances share the stimulus: dut (MAX_TIME=9999) and
//                dut_to (MAX_TIME=20, for the timeout scenario). Every
//                scenario starts from a reset so both stay aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_ctrl_mp;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       TICK  = 1'b0;
    logic       START = 1'b0;
    logic [3:0] PRESS = 4'b0000;

    logic        d_led, d_valid, d_fs, d_to;
    logic [13:0] d_time;
    logic [1:0]  d_winner;
    logic [2:0]  d_state;

    logic        t_led, t_valid, t_fs, t_to;
    logic [13:0] t_time;
    logic [1:0]  t_winner;
    logic [2:0]  t_state;

`ifdef REACTION_BEST_TIME_EN
    logic [13:0] d_best, t_best;
    logic        d_new,  t_new;
`endif

    int errors = 0;
    int checks = 0;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting left.
    logic [15:0] m_lfsr;
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    always #5 CLK = ~CLK;

    reaction_ctrl_mp #(
        .NPLAYERS (4), .TIME_W (14), .MAX_TIME (9999),
        .MIN_DELAY (5), .RAND_BITS (2), .LFSR_SEED (16'hACE1)
    ) dut (
        .CLK (CLK), .RST_N (RST_N), .TICK (TICK), .START (START), .PRESS (PRESS),
        .LED (d_led), .TIME (d_time), .WINNER (d_winner), .VALID (d_valid),
        .FALSE_START (d_fs), .TIMEOUT (d_to), .STATE (d_state)
`ifdef REACTION_BEST_TIME_EN
        , .BEST_TIME (d_best), .NEW_BEST (d_new)
`endif
    );

    reaction_ctrl_mp #(
        .NPLAYERS (4), .TIME_W (14), .MAX_TIME (20),
        .MIN_DELAY (5), .RAND_BITS (2), .LFSR_SEED (16'hACE1)
    ) dut_to (
        .CLK (CLK), .RST_N (RST_N), .TICK (TICK), .START (START), .PRESS (PRESS),
        .LED (t_led), .TIME (t_time), .WINNER (t_winner), .VALID (t_valid),
        .FALSE_START (t_fs), .TIMEOUT (t_to), .STATE (t_state)
`ifdef REACTION_BEST_TIME_EN
        , .BEST_TIME (t_best), .NEW_BEST (t_new)
`endif
    );

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST_N = 1'b0; START = 1'b0; TICK = 1'b0; PRESS = 4'b0000;
        step(); step();
        RST_N = 1'b1;
        step();
    endtask

    task automatic pulse_ticks(input int n);
        repeat (n) begin
            TICK = 1'b1; step();
            TICK = 1'b0; step();
        end
    endtask

    // START rise; returns the delay the DUT loads from the current LFSR value.
    task automatic start_round(output int dly);
        dly   = 5 + int'(m_lfsr[1:0]);
        START = 1'b1; step();
        START = 1'b0; step();
    endtask

    task automatic play_round(input int t, input logic [3:0] p);
        int dly;
        start_round(dly);
        pulse_ticks(dly);
        pulse_ticks(t);
        PRESS = p;     step();
        PRESS = 4'b0000; step();
    endtask

    task automatic clear_round();
        START = 1'b1; step();
        START = 1'b0; step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST_N = 1'b0; START = 1'b1; PRESS = 4'b1111; TICK = 1'b0;
        step();
        checks++; if (d_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", d_state); end
        checks++; if ({d_led, d_valid, d_fs, d_to} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {d_led, d_valid, d_fs, d_to}); end
        checks++; if (d_time !== 14'd0 || d_winner !== 2'd0) begin errors++; $display("FAIL reset_time_winner: got %0d/%0d expected 0/0", d_time, d_winner); end
        checks++; if (t_state !== 3'd0 || t_time !== 14'd0) begin errors++; $display("FAIL reset_dut_to: got %0d/%0d expected 0/0", t_state, t_time); end
        // Levels held high through reset release must not act as edges.
        RST_N = 1'b1; step(); step(); step();
        checks++; if (d_state !== 3'd0) begin errors++; $display("FAIL held_start_no_rise: got state %0d expected 0", d_state); end
        START = 1'b0; PRESS = 4'b0000; step();
    endtask

    task automatic test_arm_to_go();
        int dly;
        do_reset();
        start_round(dly);
        checks++; if (d_state !== 3'd1) begin errors++; $display("FAIL arm_wait: got %0d expected 1", d_state); end
        pulse_ticks(dly - 1);
        checks++; if (d_state !== 3'd1 || d_led !== 1'b0) begin errors++; $display("FAIL arm_before_last_tick: got state %0d led %b expected 1/0", d_state, d_led); end
        TICK = 1'b1; step(); TICK = 1'b0;
        checks++; if (d_state !== 3'd2) begin errors++; $display("FAIL arm_go: got %0d expected 2 (dly %0d)", d_state, dly); end
        checks++; if (d_led !== 1'b1 || d_time !== 14'd0) begin errors++; $display("FAIL go_led_time: got led %b time %0d expected 1/0", d_led, d_time); end
    endtask

    task automatic test_go_press();
        int dly;
        do_reset();
        start_round(dly);
        pulse_ticks(dly);
        // START in GO is ignored.
        START = 1'b1; step(); START = 1'b0; step();
        checks++; if (d_state !== 3'd2) begin errors++; $display("FAIL start_in_go_ignored: got %0d expected 2", d_state); end
        pulse_ticks(37);
        checks++; if (d_time !== 14'd37) begin errors++; $display("FAIL go_count: got %0d expected 37", d_time); end
        PRESS = 4'b0100; step();
        checks++; if (d_state !== 3'd3 || d_valid !== 1'b1) begin errors++; $display("FAIL press_result: got state %0d valid %b expected 3/1", d_state, d_valid); end
        checks++; if (d_winner !== 2'd2 || d_time !== 14'd37) begin errors++; $display("FAIL press_capture: got winner %0d time %0d expected 2/37", d_winner, d_time); end
        checks++; if ({d_led, d_fs, d_to} !== 3'b000) begin errors++; $display("FAIL press_other_flags: got %b expected 000", {d_led, d_fs, d_to}); end
        PRESS = 4'b0000; step();
        PRESS = 4'b0001; step();
        checks++; if (d_winner !== 2'd2 || d_valid !== 1'b1) begin errors++; $display("FAIL result_frozen: got winner %0d valid %b expected 2/1", d_winner, d_valid); end
        PRESS = 4'b0000;
        clear_round();
        checks++; if (d_state !== 3'd0 || d_valid !== 1'b0 || d_time !== 14'd0 || d_winner !== 2'd0) begin
            errors++; $display("FAIL clear_to_idle: got state %0d valid %b time %0d winner %0d expected 0/0/0/0", d_state, d_valid, d_time, d_winner);
        end
    endtask

    task automatic test_false_start();
        int dly;
        do_reset();
        start_round(dly);
        pulse_ticks(2);
        PRESS = 4'b1010; step();
        checks++; if (d_state !== 3'd4 || d_fs !== 1'b1) begin errors++; $display("FAIL fs_fault: got state %0d fs %b expected 4/1", d_state, d_fs); end
        checks++; if (d_winner !== 2'd1 || d_valid !== 1'b0 || d_time !== 14'd0) begin errors++; $display("FAIL fs_capture: got winner %0d valid %b time %0d expected 1/0/0", d_winner, d_valid, d_time); end
        PRESS = 4'b0000;
        pulse_ticks(10);
        checks++; if (d_led !== 1'b0 || d_state !== 3'd4) begin errors++; $display("FAIL fs_no_led: got led %b state %0d expected 0/4", d_led, d_state); end
        // Press on the very tick that would arm GO.
        do_reset();
        start_round(dly);
        pulse_ticks(dly - 1);
        TICK = 1'b1; PRESS = 4'b1000; step();
        TICK = 1'b0; PRESS = 4'b0000;
        checks++; if (d_state !== 3'd4 || d_fs !== 1'b1 || d_winner !== 2'd3) begin
            errors++; $display("FAIL fs_last_tick: got state %0d fs %b winner %0d expected 4/1/3", d_state, d_fs, d_winner);
        end
    endtask

    task automatic test_timeout();
        int dly;
        do_reset();
        start_round(dly);
        pulse_ticks(dly);
        pulse_ticks(19);
        checks++; if (t_state !== 3'd2 || t_time !== 14'd19) begin errors++; $display("FAIL to_before: got state %0d time %0d expected 2/19", t_state, t_time); end
        TICK = 1'b1; step(); TICK = 1'b0;
        checks++; if (t_state !== 3'd3 || t_to !== 1'b1) begin errors++; $display("FAIL to_result: got state %0d timeout %b expected 3/1", t_state, t_to); end
        checks++; if (t_time !== 14'd20 || t_valid !== 1'b0 || t_winner !== 2'd0) begin errors++; $display("FAIL to_values: got time %0d valid %b winner %0d expected 20/0/0", t_time, t_valid, t_winner); end
        PRESS = 4'b0010; step(); PRESS = 4'b0000;
        checks++; if (t_to !== 1'b1 || t_valid !== 1'b0 || t_fs !== 1'b0 || t_led !== 1'b0) begin
            errors++; $display("FAIL to_frozen: got to %b valid %b fs %b led %b expected 1/0/0/0", t_to, t_valid, t_fs, t_led);
        end
    endtask

    task automatic test_coincident_and_reset();
        int dly;
        do_reset();
        start_round(dly);
        pulse_ticks(dly);
        pulse_ticks(12);
        TICK = 1'b1; PRESS = 4'b0001; step();
        TICK = 1'b0; PRESS = 4'b0000;
        checks++; if (d_time !== 14'd12 || d_valid !== 1'b1 || d_winner !== 2'd0 || d_state !== 3'd3) begin
            errors++; $display("FAIL coincident_tick: got time %0d valid %b winner %0d state %0d expected 12/1/0/3", d_time, d_valid, d_winner, d_state);
        end
        do_reset();
        start_round(dly);
        pulse_ticks(dly);
        pulse_ticks(5);
        checks++; if (d_state !== 3'd2 || d_time !== 14'd5) begin errors++; $display("FAIL pre_reset_go: got state %0d time %0d expected 2/5", d_state, d_time); end
        #2 RST_N = 1'b0;
        #1;
        checks++; if (d_state !== 3'd0 || d_led !== 1'b0 || d_time !== 14'd0) begin
            errors++; $display("FAIL async_reset: got state %0d led %b time %0d expected 0/0/0", d_state, d_led, d_time);
        end
        @(negedge CLK); RST_N = 1'b1; step();
    endtask

`ifdef REACTION_BEST_TIME_EN
    task automatic test_best_time();
        do_reset();
        checks++; if (d_best !== 14'd9999 || d_new !== 1'b0 || t_best !== 14'd20 || t_new !== 1'b0) begin
            errors++; $display("FAIL best_reset: got %0d/%b/%0d/%b expected 9999/0/20/0", d_best, d_new, t_best, t_new);
        end
        play_round(30, 4'b0001);
        checks++; if (d_best !== 14'd30 || d_new !== 1'b1) begin errors++; $display("FAIL best_r1: got %0d/%b expected 30/1", d_best, d_new); end
        clear_round();
        checks++; if (d_best !== 14'd30 || d_new !== 1'b0) begin errors++; $display("FAIL best_clear: got %0d/%b expected 30/0", d_best, d_new); end
        play_round(25, 4'b0010);
        checks++; if (d_best !== 14'd25 || d_new !== 1'b1) begin errors++; $display("FAIL best_r2: got %0d/%b expected 25/1", d_best, d_new); end
        clear_round();
        play_round(25, 4'b0100);
        checks++; if (d_best !== 14'd25 || d_new !== 1'b0 || d_valid !== 1'b1) begin
            errors++; $display("FAIL best_r3_equal: got %0d/%b valid %b expected 25/0/1", d_best, d_new, d_valid);
        end
    endtask
`endif

    initial begin
        @(negedge CLK);
        test_reset();
        test_arm_to_go();
        test_go_press();
        test_false_start();
        test_timeout();
        test_coincident_and_reset();
`ifdef REACTION_BEST_TIME_EN
        test_best_time();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule : tb_reaction_ctrl_mp
`default_nettype wire

// File: doc/reaction_ctrl_mp.md
Name: reaction_ctrl_mp

Overview:
- Parametrised multi-player reaction-timer controller; successor to the single-player 4-state game FSM.
- Fully synchronous: edge detection on START and PRESS inputs, internal pseudo-random arm delay, saturating reaction timer, false-start and timeout detection, winner arbitration.
- Sits between the debounced key/switch inputs, the 1 ms tick generator and the BCD display/LED drivers.

Parameters:
- NPLAYERS, 2: number of player buttons (1..8).
- TIME_W, 14: reaction time width in ticks.
- MAX_TIME, 9999: saturation value; reaching it ends the round as timeout (must be < 2^TIME_W).
- MIN_DELAY, 1000: minimum arm delay in ticks.
- RAND_BITS, 11: LFSR bits added to MIN_DELAY (1..16); MIN_DELAY + 2^RAND_BITS - 1 must be < 65536.
- LFSR_SEED, 16'hACE1: non-zero LFSR reset value.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- TICK  in  1  one-CLK-wide timebase pulse (1 ms).
- START  in  1  level, debounced; acted on at its rising edge.
- PRESS  in  NPLAYERS  level per player, debounced; acted on at rising edges.
- LED  out  1  stimulus lamp; high only in GO.
- TIME  out  TIME_W  captured/running reaction time.
- WINNER  out  PW  player index, where PW = max(1, clog2(NPLAYERS)).
- VALID  out  1  round finished with a winner.
- FALSE_START  out  1  press during WAIT.
- TIMEOUT  out  1  no press before MAX_TIME.
- STATE  out  3  current state encoding, for the debug display.

Behaviour:
- Reset (async assert, sync release): state IDLE; LED=0, TIME=0, WINNER=0, VALID=0, FALSE_START=0, TIMEOUT=0, STATE=IDLE; edge registers cleared to 0; LFSR=LFSR_SEED.
- Edge detect: start_q/press_q register the inputs every CLK. rise = input & ~input_q. Action occurs on the same edge that updates input_q, so latency from input high to state change is 1 CLK. A level held high through reset does not produce a rise.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every CLK in every state.
- IDLE (0): TIME=0, all flags 0. START rise -> WAIT; dly_cnt <= MIN_DELAY + lfsr[RAND_BITS-1:0].
- WAIT (1):
  - Any PRESS rise -> FAULT; FALSE_START=1; WINNER = lowest set index.
  - Else on TICK: dly_cnt decrements; a TICK with dly_cnt==1 -> GO with TIME=0.
  - A press in the same cycle as that final TICK is a false start.
- GO (2):
  - LED=1.
  - Any PRESS rise -> RESULT; VALID=1; WINNER = lowest set index; TIME holds its current value. A TICK in the same cycle is not counted.
  - Else TICK increments TIME; the TICK that makes TIME==MAX_TIME -> RESULT with TIMEOUT=1, VALID=0, WINNER=0, TIME=MAX_TIME.
- RESULT (3) / FAULT (4): outputs frozen; further presses ignored. START rise -> IDLE (clear).
- START rise in WAIT or GO: ignored.
- Encodings 5-7 are unreachable; if entered -> IDLE next CLK.
- Flags are mutually exclusive; at most one of VALID, FALSE_START and TIMEOUT is high.
- RST_N low in any state: immediate return to reset values, including mid-WAIT and mid-GO.

Optional Feature:
- Macro REACTION_BEST_TIME_EN.
- Defined: adds ports BEST_TIME (TIME_W, out) and NEW_BEST (1, out).
  - BEST_TIME resets to MAX_TIME.
  - On entry to RESULT with VALID=1 and TIME < BEST_TIME: BEST_TIME <= TIME and NEW_BEST=1 until the next START rise.
  - Equal times do not update BEST_TIME.
  - BEST_TIME survives round clears; only RST_N resets it.
- Undefined: ports absent; no best-time register.

Decomposition:
- Package reaction_pkg: state enum/localparams (IDLE=0, WAIT=1, GO=2, RESULT=3, FAULT=4), LFSR tap mask, default seed, function for the PW width.
- Sub-module lfsr16 (seed parameter, free-running, q output).
- Arbitration (lowest index) stays inline.

Test Plan:
- Bench overrides: MIN_DELAY=5, RAND_BITS=2, LFSR_SEED=16'hACE1, NPLAYERS=4.
  1. START rise in IDLE -> WAIT, dly_cnt = 5 + (seed-derived lfsr[1:0]) computed by the model; GO entered on exactly that TICK; LED=1.
  2. In GO, 37 TICKs then PRESS=4'b0100 -> RESULT, VALID=1, WINNER=2, TIME=37, 1 CLK after the press edge.
  3. PRESS=4'b1010 during WAIT -> FAULT, FALSE_START=1, WINNER=1, LED never asserted.
  4. GO with no press and MAX_TIME=20 -> RESULT after the 20th TICK, TIMEOUT=1, TIME=20, VALID=0.
  5. PRESS rise coincident with TICK in GO at TIME=12 -> TIME=12; RST_N pulsed low mid-GO -> all outputs 0 immediately, STATE=IDLE.
  6. With REACTION_BEST_TIME_EN: rounds of 30, 25, 25 -> BEST_TIME 30, then 25 with NEW_BEST=1, then 25 with NEW_BEST=0.
